prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker_pkg.sv | 23 ++
 rtl/prbs_checker_predict.sv | 11 +
 rtl/prbs_checker.sv | 208 ++++++++++++++++++++
 tb/tb_prbs_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_checker_pkg.sv
// Shared constants, tap mask and state encoding for the 54-stage pin-test PRBS checker.
package prbs_pkg;

  localparam int PRBS_LEN = 54;

  localparam int TAP_A = 53;
  localparam int TAP_B = 52;
  localparam int TAP_C = 17;
  localparam int TAP_D = 16;

  // One bit set per tap, so the prediction is a single XOR-reduce over hist.
  localparam logic [PRBS_LEN-1:0] TAP_MASK = (PRBS_LEN'(1) << TAP_A)
                                           | (PRBS_LEN'(1) << TAP_B)
                                           | (PRBS_LEN'(1) << TAP_C)
                                           | (PRBS_LEN'(1) << TAP_D);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/prbs_checker_predict.sv
// Next-bit predictor for x[n] = x[n-54]^x[n-53]^x[n-18]^x[n-17]; hist[0] is the newest bit.
module prbs_predict
  import prbs_pkg::*;
(
  input  logic [PRBS_LEN-1:0] hist,
  output logic                p
);

  assign p = ^(hist & TAP_MASK);

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: fill / verify / locked flywheel with windowed loss-of-lock and error counting.
// Define PRBS_CHECKER_INJECT_EN to let inj_err invert din ahead of the compare.
//
// state  | meaning
// FILL   | loading 54 received bits into the history
// VERIFY | counting consecutive correct predictions toward lock
// LOCKED | flywheel running on predicted bits, counting errors per window
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 64,
  parameter int WINDOW   = 256,
  parameter int LOSS_ERR = 8
) (
  input  logic        fclk,
  input  logic        zrst_n,
  input  logic        din,
  input  logic        din_vld,
  input  logic        clr_cnt,
  input  logic        inj_err,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [1:0]  state
);

  localparam int FILL_W = $clog2(PRBS_LEN);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WERR_W = $clog2(LOSS_ERR + 1);

  state_e                state_q, state_d;
  logic [PRBS_LEN-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]     fill_cnt_q, fill_cnt_d;
  logic [GOOD_W-1:0]     good_cnt_q, good_cnt_d;
  logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]     win_err_q, win_err_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic                  err_pulse_q, err_pulse_d;

  logic din_eff;
  logic p;
  logic mismatch;
  logic hist_zero;
  logic fill_done;
  logic lock_hit;
  logic verify_fail;
  logic win_wrap;
  logic lock_err;
  logic loss_hit;

`ifdef PRBS_CHECKER_INJECT_EN
  assign din_eff = din ^ inj_err;
`else
  logic unused_inj_err;
  assign unused_inj_err = inj_err;
  assign din_eff        = din;
`endif

  prbs_predict u_predict (
    .hist (hist_q),
    .p    (p)
  );

  assign mismatch    = (din_eff != p);
  assign hist_zero   = (hist_q == '0);
  assign fill_done   = din_vld && (state_q == FILL)
                       && (fill_cnt_q == FILL_W'(PRBS_LEN - 1));
  assign verify_fail = din_vld && (state_q == VERIFY) && mismatch;
  // A constant-zero history predicts 0 forever, so it must never earn lock credit.
  assign lock_hit    = din_vld && (state_q == VERIFY) && !mismatch && !hist_zero
                       && (good_cnt_q == GOOD_W'(LOCK_CNT - 1));
  assign win_wrap    = (win_cnt_q == WIN_W'(WINDOW - 1));
  assign lock_err    = din_vld && (state_q == LOCKED) && mismatch;
  assign loss_hit    = lock_err && (win_err_q == WERR_W'(LOSS_ERR - 1));

  // State register
  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (fill_done) state_d = VERIFY;
      end
      VERIFY: begin
        if (verify_fail)   state_d = FILL;
        else if (lock_hit) state_d = LOCKED;
      end
      LOCKED: begin
        if (loss_hit) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Output logic
  always_comb begin
    locked    = (state_q == LOCKED);
    state     = state_q;
    err_pulse = err_pulse_q;
    err_cnt   = err_cnt_q;
  end

  // History and per-state counters
  always_comb begin
    hist_d     = hist_q;
    fill_cnt_d = fill_cnt_q;
    good_cnt_d = good_cnt_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    case (state_q)
      FILL: begin
        if (din_vld) begin
          hist_d = {hist_q[PRBS_LEN-2:0], din_eff};
          if (fill_done) begin
            fill_cnt_d = '0;
            good_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      VERIFY: begin
        if (din_vld) begin
          hist_d = {hist_q[PRBS_LEN-2:0], din_eff};
          if (verify_fail) begin
            fill_cnt_d = '0;
            good_cnt_d = '0;
          end else if (lock_hit) begin
            good_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (!hist_zero) begin
            good_cnt_d = good_cnt_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (din_vld) begin
          if (loss_hit) begin
            hist_d     = '0;
            fill_cnt_d = '0;
            good_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else begin
            // Flywheel: the history follows the prediction, not the line.
            hist_d = {hist_q[PRBS_LEN-2:0], p};
            if (win_wrap) begin
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + 1'b1;
              win_err_d = win_err_q + WERR_W'(lock_err);
            end
          end
        end
      end
      default: begin
        hist_d     = '0;
        fill_cnt_d = '0;
        good_cnt_d = '0;
        win_cnt_d  = '0;
        win_err_d  = '0;
      end
    endcase
  end

  // Error reporting; a clear in the same cycle as an error wins.
  always_comb begin
    err_pulse_d = lock_err;
    err_cnt_d   = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (lock_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) begin
      hist_q      <= '0;
      fill_cnt_q  <= '0;
      good_cnt_q  <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      fill_cnt_q  <= fill_cnt_d;
      good_cnt_q  <= good_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: stimulus queues expected values, a negedge monitor compares.
module tb_prbs_checker;

  logic        fclk    = 1'b0;
  logic        zrst_n  = 1'b0;
  logic        din     = 1'b0;
  logic        din_vld = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        inj_err = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  always #5 fclk = ~fclk;

  prbs_checker #(.LOCK_CNT(64), .WINDOW(256), .LOSS_ERR(8)) dut (
    .fclk      (fclk),
    .zrst_n    (zrst_n),
    .din       (din),
    .din_vld   (din_vld),
    .clr_cnt   (clr_cnt),
    .inj_err   (inj_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  localparam int SEL_LOCKED = 0;
  localparam int SEL_PULSE  = 1;
  localparam int SEL_CNT    = 2;
  localparam int SEL_STATE  = 3;
  localparam int SEL_NOLOCK = 4;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [53:0] g;

  always @(posedge fclk) cyc <= cyc + 1;

  function automatic int observe(input int sel);
    case (sel)
      SEL_LOCKED: return int'(locked);
      SEL_PULSE:  return int'(err_pulse);
      SEL_CNT:    return int'(err_cnt);
      SEL_STATE:  return int'(state);
      default:    return (state == 2'd0 || state == 2'd1) ? 1 : 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge fclk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      check(mon_e.name, observe(mon_e.sel), mon_e.val);
    end
  end

  // Expectation for the cycle after the inputs currently being driven are captured.
  task automatic expect_v(input int sel, input int val, input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic drive(input logic d, input logic v, input logic c, input logic inj);
    @(posedge fclk);
    #1;
    din     = d;
    din_vld = v;
    clr_cnt = c;
    inj_err = inj;
  endtask

  task automatic next_bit(output logic b);
    b = g[53] ^ g[52] ^ g[17] ^ g[16];
    g = {g[52:0], b};
  endtask

  task automatic send_bit(input logic flip);
    logic b;
    next_bit(b);
    drive(b ^ flip, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge fclk);
    #1;
    zrst_n = 1'b0;
    #2;
    @(posedge fclk);
    #1;
    zrst_n = 1'b1;
    g = 54'h1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, queue %0d entries", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    g = 54'h1;
    #3;
    check("reset_state",     int'(state),     0);
    check("reset_locked",    int'(locked),    0);
    check("reset_err_cnt",   int'(err_cnt),   0);
    check("reset_err_pulse", int'(err_pulse), 0);
    @(posedge fclk);
    #1;
    zrst_n = 1'b1;

    // Clean stream: lock visible after sample 118, none after 10000 bits.
    for (int i = 1; i <= 10000; i++) begin
      send_bit(1'b0);
      if (i == 54)    expect_v(SEL_STATE, 1, "a_verify_after_fill");
      if (i == 117)   expect_v(SEL_LOCKED, 0, "a_not_locked_117");
      if (i == 118)   expect_v(SEL_LOCKED, 1, "a_locked_118");
      if (i == 118)   expect_v(SEL_STATE, 2, "a_state_locked");
      if (i == 10000) expect_v(SEL_CNT, 0, "a_err_cnt_10000");
      if (i == 10000) expect_v(SEL_LOCKED, 1, "a_locked_10000");
    end

    // Single flip at bit 500, then clear coincident with an error.
    do_reset();
    for (int i = 1; i <= 800; i++) begin
      send_bit(i == 500);
      if (i == 499) expect_v(SEL_PULSE, 0, "b_no_pulse_499");
      if (i == 500) expect_v(SEL_PULSE, 1, "b_pulse_500");
      if (i == 500) expect_v(SEL_CNT, 1, "b_err_cnt_500");
      if (i == 501) expect_v(SEL_PULSE, 0, "b_no_pulse_501");
      if (i == 800) expect_v(SEL_CNT, 1, "b_err_cnt_800");
      if (i == 800) expect_v(SEL_LOCKED, 1, "b_locked_800");
    end
    begin
      logic b;
      next_bit(b);
      drive(~b, 1'b1, 1'b1, 1'b0);
      expect_v(SEL_CNT, 0, "g_clr_vs_err_cnt");
      expect_v(SEL_PULSE, 1, "g_clr_vs_err_pulse");
    end
    send_bit(1'b0);
    expect_v(SEL_CNT, 0, "g_cnt_after_clr");

    // Eight flips in one window: lose lock on the 8th, relock 118 bits later.
    do_reset();
    for (int i = 1; i <= 400; i++) begin
      send_bit(i >= 130 && i <= 200 && (i % 10) == 0);
      if (i == 190) expect_v(SEL_LOCKED, 1, "c_locked_after_7");
      if (i == 190) expect_v(SEL_CNT, 7, "c_err_cnt_7");
      if (i == 200) expect_v(SEL_LOCKED, 0, "c_unlocked_after_8");
      if (i == 200) expect_v(SEL_STATE, 0, "c_state_fill");
      if (i == 200) expect_v(SEL_CNT, 8, "c_err_cnt_8");
      if (i == 317) expect_v(SEL_LOCKED, 0, "c_not_relocked_317");
      if (i == 318) expect_v(SEL_LOCKED, 1, "c_relocked_318");
      if (i == 400) expect_v(SEL_CNT, 8, "c_err_cnt_kept");
    end

    // Constant zero must never lock.
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (i % 100 == 0) expect_v(SEL_NOLOCK, 1, "d_state_fill_or_verify");
      if (i % 100 == 0) expect_v(SEL_LOCKED, 0, "d_not_locked");
    end

    // 50% valid duty with garbage on idle cycles: lock after 118 valid samples.
    do_reset();
    for (int k = 1; k <= 118; k++) begin
      send_bit(1'b0);
      if (k == 118) expect_v(SEL_LOCKED, 1, "e_locked_118_valid");
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      if (k == 117) expect_v(SEL_LOCKED, 0, "e_not_locked_117_valid");
      if (k == 118) expect_v(SEL_PULSE, 0, "e_no_pulse_idle");
    end

    // Asynchronous reset mid-lock with a nonzero error count.
    send_bit(1'b1);
    expect_v(SEL_CNT, 1, "f_err_cnt_before_reset");
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge fclk);
    #2;
    check("f_locked_before_reset", int'(locked), 1);
    zrst_n = 1'b0;
    #1;
    check("f_async_locked",  int'(locked),  0);
    check("f_async_err_cnt", int'(err_cnt), 0);
    check("f_async_state",   int'(state),   0);
    @(posedge fclk);
    #1;
    zrst_n = 1'b1;
    g = 54'h1;

`ifdef PRBS_CHECKER_INJECT_EN
    for (int i = 1; i <= 150; i++) send_bit(1'b0);
    begin
      logic b;
      next_bit(b);
      drive(b, 1'b1, 1'b0, 1'b1);
      expect_v(SEL_CNT, 1, "h_inject_err_cnt");
      expect_v(SEL_PULSE, 1, "h_inject_pulse");
    end
    send_bit(1'b0);
    expect_v(SEL_CNT, 1, "h_inject_single");
`endif

    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge fclk);
    #1;
    check("scoreboard_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
